// File: rtl/sseg_scan_decoder.sv
// Observer for a multiplexed active-low 7-segment bus: debounces each digit dwell,
// decodes it to a nibble and reassembles the four digits into a 16-bit frame.
module sseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_blank,
    output logic        decode_err,
    output logic        scan_lost
);

    localparam int unsigned RUN_W  = (STABLE_CYCLES  > 2) ? $clog2(STABLE_CYCLES)  : 1;
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0]  RUN_ARM  = RUN_W'(STABLE_CYCLES - 2);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(TIMEOUT_CYCLES - 2);

    logic [10:0]       pat_q;
    logic [RUN_W-1:0]  run_q;
    logic [IDLE_W-1:0] idle_q;
    logic [3:0]        seen;
    logic [15:0]       slots_q;

    logic              same;
    logic              an_ok;
    logic [1:0]        slot;
    logic              seg_hit;
    logic [3:0]        seg_nib;
    logic              capture;
    logic              cap_hit;
    logic              cap_miss;
    logic              timeout_hit;
    logic [3:0]        seen_set;
    logic [15:0]       slots_new;

    always_comb begin
        an_ok = 1'b1;
        slot  = 2'd0;
        case (pat_q[10:7])
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: an_ok = 1'b0;
        endcase
    end

    always_comb begin
        seg_hit = 1'b1;
        seg_nib = 4'h0;
        case (pat_q[6:0])
            7'h40: seg_nib = 4'h0;
            7'h79: seg_nib = 4'h1;
            7'h24: seg_nib = 4'h2;
            7'h30: seg_nib = 4'h3;
            7'h19: seg_nib = 4'h4;
            7'h12: seg_nib = 4'h5;
            7'h02: seg_nib = 4'h6;
            7'h78: seg_nib = 4'h7;
            7'h00: seg_nib = 4'h8;
            7'h10: seg_nib = 4'h9;
            7'h08: seg_nib = 4'hA;
            7'h03: seg_nib = 4'hB;
            7'h46: seg_nib = 4'hC;
            7'h21: seg_nib = 4'hD;
            7'h06: seg_nib = 4'hE;
            7'h7F: seg_nib = 4'hF;
            default: seg_hit = 1'b0;
        endcase
    end

    // Capture only on the single edge where the run counter reaches its saturated value.
    always_comb begin
        same        = ({an, sseg} == pat_q);
        capture     = same && (run_q == RUN_ARM) && an_ok;
        cap_hit     = capture && seg_hit;
        cap_miss    = capture && !seg_hit;
        timeout_hit = !capture && (idle_q >= IDLE_PRE);
        seen_set    = seen | (4'b0001 << slot);
        slots_new   = slots_q;
        slots_new[{slot, 2'b00} +: 4] = seg_nib;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q       <= {4'hF, 7'h7F};
            run_q       <= '0;
            idle_q      <= '0;
            seen        <= '0;
            slots_q     <= '0;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_blank <= 1'b0;
            decode_err  <= 1'b0;
            scan_lost   <= 1'b0;
        end else begin
            pat_q       <= {an, sseg};
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;

            if (!same)
                run_q <= '0;
            else if (run_q != RUN_MAX)
                run_q <= run_q + RUN_W'(1);

            if (capture)
                idle_q <= '0;
            else if (idle_q != IDLE_MAX)
                idle_q <= idle_q + IDLE_W'(1);

            if (timeout_hit) begin
                scan_lost <= 1'b1;
                seen      <= '0;
            end

            if (cap_miss)
                decode_err <= 1'b1;

            if (cap_hit) begin
                slots_q   <= slots_new;
                scan_lost <= 1'b0;
                if (seen_set == 4'b1111) begin
                    value       <= slots_new;
                    frame_blank <= (slots_new == 16'hFFFF);
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= seen_set;
                end
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_sseg_scan_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [15:0] value;
    logic        frame_valid;
    logic        frame_blank;
    logic        decode_err;
    logic        scan_lost;

    int n_checks = 0;
    int n_fails  = 0;
    int fv_cnt   = 0;
    int de_cnt   = 0;
    int fv0;
    int de0;

    sseg_scan_decoder #(
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .sseg       (sseg),
        .value      (value),
        .frame_valid(frame_valid),
        .frame_blank(frame_blank),
        .decode_err (decode_err),
        .scan_lost  (scan_lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (decode_err === 1'b1) de_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an   = a;
        sseg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        an    = 4'hF;
        sseg  = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_value", value, 16'h0000);
        check("rst_fv", {15'd0, frame_valid}, 16'd0);
        check("rst_fb", {15'd0, frame_blank}, 16'd0);
        check("rst_de", {15'd0, decode_err}, 16'd0);
        check("rst_sl", {15'd0, scan_lost}, 16'd0);
        check("rst_seen", {12'd0, dut.seen}, 16'd0);

        // Normal scan of 16'h1234
        hold(4'b1110, 7'h19, 4);
        check("n1_seen", {12'd0, dut.seen}, 16'h0001);
        hold(4'b1101, 7'h30, 4);
        hold(4'b1011, 7'h24, 4);
        check("n3_fv", {15'd0, frame_valid}, 16'd0);
        hold(4'b0111, 7'h79, 4);
        check("n_fv", {15'd0, frame_valid}, 16'd1);
        check("n_value", value, 16'h1234);
        check("n_fb", {15'd0, frame_blank}, 16'd0);

        // Glitch: 3-cycle dwell must not capture
        hold(4'b1110, 7'h40, 3);
        hold(4'b1111, 7'h7F, 1);
        check("g_seen", {12'd0, dut.seen}, 16'h0000);
        check("g_fvcnt", 16'(fv_cnt), 16'd1);
        hold(4'b1110, 7'h40, 4);
        check("g_seen4", {12'd0, dut.seen}, 16'h0001);
        hold(4'b1101, 7'h12, 4);
        hold(4'b1011, 7'h10, 4);
        hold(4'b0111, 7'h40, 4);
        check("g_fv", {15'd0, frame_valid}, 16'd1);
        check("g_value", value, 16'h0950);

        // Blank frame then normal frame
        hold(4'b1110, 7'h7F, 4);
        hold(4'b1101, 7'h7F, 4);
        hold(4'b1011, 7'h7F, 4);
        hold(4'b0111, 7'h7F, 4);
        check("b_fv", {15'd0, frame_valid}, 16'd1);
        check("b_value", value, 16'hFFFF);
        check("b_fb", {15'd0, frame_blank}, 16'd1);
        hold(4'b1110, 7'h40, 4);
        hold(4'b1101, 7'h12, 4);
        hold(4'b1011, 7'h10, 4);
        hold(4'b0111, 7'h40, 4);
        check("b2_value", value, 16'h0950);
        check("b2_fb", {15'd0, frame_blank}, 16'd0);

        // Decode error: long-held bad pattern pulses once
        de0 = de_cnt;
        hold(4'b1011, 7'h55, 8);
        check("e_decnt", 16'(de_cnt - de0), 16'd1);
        check("e_de_low", {15'd0, decode_err}, 16'd0);
        check("e_seen", {12'd0, dut.seen}, 16'h0000);
        fv0 = fv_cnt;
        hold(4'b1110, 7'h40, 4);
        hold(4'b1101, 7'h40, 4);
        hold(4'b0111, 7'h40, 4);
        check("e_seen3", {12'd0, dut.seen}, 16'h000B);
        check("e_nofv", 16'(fv_cnt - fv0), 16'd0);
        hold(4'b1011, 7'h24, 4);
        check("e_fv", {15'd0, frame_valid}, 16'd1);
        check("e_value", value, 16'h0200);

        // Timeout after two digits
        hold(4'b1110, 7'h19, 4);
        hold(4'b1101, 7'h30, 4);
        check("t_seen2", {12'd0, dut.seen}, 16'h0003);
        hold(4'b1111, 7'h7F, 62);
        check("t_sl_early", {15'd0, scan_lost}, 16'd0);
        hold(4'b1111, 7'h7F, 2);
        check("t_sl", {15'd0, scan_lost}, 16'd1);
        check("t_seen0", {12'd0, dut.seen}, 16'h0000);
        hold(4'b1110, 7'h19, 4);
        check("t_sl_clr", {15'd0, scan_lost}, 16'd0);
        check("t_seen1", {12'd0, dut.seen}, 16'h0001);
        hold(4'b1101, 7'h30, 4);
        hold(4'b1011, 7'h24, 4);
        check("t_nofv", {15'd0, frame_valid}, 16'd0);
        hold(4'b0111, 7'h79, 4);
        check("t_fv", {15'd0, frame_valid}, 16'd1);
        check("t_value", value, 16'h1234);

        // Reset mid-frame
        hold(4'b1110, 7'h40, 4);
        hold(4'b1101, 7'h12, 4);
        hold(4'b1011, 7'h10, 4);
        check("r_seen3", {12'd0, dut.seen}, 16'h0007);
        reset = 1'b1;
        an    = 4'hF;
        sseg  = 7'h7F;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("r_value", value, 16'h0000);
        check("r_fv", {15'd0, frame_valid}, 16'd0);
        check("r_fb", {15'd0, frame_blank}, 16'd0);
        check("r_de", {15'd0, decode_err}, 16'd0);
        check("r_sl", {15'd0, scan_lost}, 16'd0);
        check("r_seen", {12'd0, dut.seen}, 16'h0000);
        fv0 = fv_cnt;
        hold(4'b0111, 7'h40, 4);
        check("r_seen1", {12'd0, dut.seen}, 16'h0008);
        check("r_nofv", {15'd0, frame_valid}, 16'd0);
        hold(4'b1111, 7'h7F, 2);
        check("r_fvcnt", 16'(fv_cnt - fv0), 16'd0);
        check("r_value2", value, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side counterpart of the multiplexed 7-segment display driver. The block samples the time-multiplexed anode/segment outputs (`an`, `sseg`) and decodes each digit back into a nibble. It reassembles the four digits into the 16-bit code the driver was given, with 4'hF standing for a blank digit. It sits on the parking meter's display bus as an observer, for board-level self-check and as a scoreboard front end in system benches.

## Interface
- `STABLE_CYCLES`, 16: consecutive identical samples required before a digit is accepted (min 2).
- `TIMEOUT_CYCLES`, 2^20: cycles without any accepted digit before the scan is declared lost.
- `clk` in 1: system clock, same domain as the display driver.
- `reset` in 1: synchronous, active-high.
- `an` in 4: anode enables, active-low; `an[0]` is the rightmost digit.
- `sseg` in 7: segments, active-low, `{g,f,e,d,c,b,a}`, with `a` = bit 0.
- `value` out 16: last complete frame; `value[3:0]` is the `an[0]` digit and `value[15:12]` is the `an[3]` digit.
- `frame_valid` out 1: one-cycle pulse when `value` updates.
- `frame_blank` out 1: the last frame was 16'hFFFF; valid with `value`.
- `decode_err` out 1: one-cycle pulse when a stable pattern is not in the code table.
- `scan_lost` out 1: level; no digit accepted for `TIMEOUT_CYCLES` cycles.

## Operation
- **Input stage:** `{an, sseg}` is registered into `pat_q` every cycle. The run counter `run` clears when the raw input differs from `pat_q` and otherwise increments, saturating at `STABLE_CYCLES-1`.
- **Valid anode:** exactly one bit of `an` is low. Any other `an` value (all high, or several low) is never captured, does not produce `decode_err`, and still clears `run` on change.
- **Code table** (hex, active-low): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 7F (blank)→F. Every other pattern is an error.
- **Capture:** fires on the edge where `run` steps from `STABLE_CYCLES-2` to `STABLE_CYCLES-1` with a valid anode. It fires once per dwell; a pattern held longer is not re-captured until it changes.
  - Table hit: the nibble is stored into digit slot `i` (the low `an` bit) and `seen[i]` is set. If the slot is already set, it is overwritten and `seen` is unchanged.
  - Table miss: `decode_err` pulses, and the slot and `seen` are unchanged.
- **Frame completion:** on the capture edge where `seen` becomes 4'b1111:
  - `value` loads all four slots, including the nibble captured on this edge.
  - `frame_blank` is set to (new value == 16'hFFFF).
  - `frame_valid` pulses.
  - `seen` clears to 4'b0000.
- **Timeout:**
  - The idle counter clears on every capture, including error captures, and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES-1`, `scan_lost` is set, `seen` is cleared, and the counter holds.
  - `scan_lost` clears on the next table-hit capture.
- **Reset values:** `value` = 16'h0000, `frame_valid` = 0, `frame_blank` = 0, `decode_err` = 0, `scan_lost` = 0, `seen` = 0, `run` = 0, idle counter = 0, `pat_q` = {4'hF, 7'h7F}.
- **Reset mid-frame:** partially collected digits are discarded, and the next frame needs four fresh captures.

## Timing
- A pattern first present before edge k is captured at edge k+`STABLE_CYCLES`-1 if held through that edge. The capture is therefore visible in the cycle after that edge.
- A pattern held for `STABLE_CYCLES`-1 cycles is never captured.
- `frame_valid`, `decode_err` and the `value`/`frame_blank` update are all registered on the capture edge and high for exactly one cycle. `frame_valid` and `decode_err` are mutually exclusive.
- Minimum frame period: 4×`STABLE_CYCLES` cycles.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- **Normal scan:** `STABLE_CYCLES`=4. Drive the driver pattern for 16'h1234: `an`=1110/`sseg`=19, then 1101/30, 1011/24, 0111/79, each held 4 cycles. Expect one `frame_valid` after the 4th dwell, `value`=16'h1234, `frame_blank`=0.
- **Glitch rejection:** hold `an`=1110/`sseg`=40 for 3 cycles, then change it. Expect no capture and `seen` still 0. Then hold the same pattern for 4 cycles: it is captured.
- **Blank (flash) frame:** all four digits at `sseg`=7F. Expect `value`=16'hFFFF, `frame_blank`=1. A following normal frame 16'h0950 gives `frame_blank`=0.
- **Decode error:** stable `sseg`=7'h55 on `an`=1011. Expect a single `decode_err` pulse and no frame. The other three digits alone do not complete a frame.
- **Timeout:** `TIMEOUT_CYCLES`=64. Capture two digits, then drive `an`=1111 for 64 cycles. Expect `scan_lost`=1 and `seen` cleared. The next valid capture clears `scan_lost`, and a frame then needs all four digits.
- **Reset mid-frame:** capture three digits, assert `reset` for 1 cycle, then capture only the fourth digit. Expect no `frame_valid`, and every output at its reset value right after reset.
